// File: rtl/upsample_tile_ctrl_pkg.sv
// Shared definitions for the upsampling tile-input sequencer: FSM state
// encoding, tile/window geometry and the window address helper.
package upsample_tile_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SWEEP = 2'd2
    } state_e;

    localparam int TILE_W       = 4;
    localparam int WIN_PER_SIDE = 3;
    localparam int WIN_PER_TILE = 9;

    // Top-left address of the 2x2 window at (r,c): r*TILE_W + c.
    // With TILE_W=4 the multiply is a 2-bit shift.
    function automatic logic [3:0] win_addr(input logic [1:0] r, input logic [1:0] c);
        return {r, 2'b00} + {2'b00, c};
    endfunction

endpackage

// File: rtl/upsample_tile_ctrl_if.sv
// Handshake and tile-register control bundle of the tile sequencer.
// master = controller side, slave = upstream/downstream/tile-register side.
interface upsample_tile_ctrl_if #(
    parameter int TIDX_W = 8,
    parameter int ADDR_W = 6
);
    logic              tile_valid;
    logic              tile_ready;
    logic              en_write_in;
    logic [ADDR_W-1:0] addr_input;
    logic              win_valid;
    logic              win_ready;
    logic [1:0]        win_row;
    logic [1:0]        win_col;
    logic              win_last;
    logic              frame_last;
    logic [TIDX_W-1:0] tile_idx;
    logic              busy;

    modport master (
        input  tile_valid, win_ready,
        output tile_ready, en_write_in, addr_input, win_valid, win_row, win_col,
               win_last, frame_last, tile_idx, busy
    );

    modport slave (
        output tile_valid, win_ready,
        input  tile_ready, en_write_in, addr_input, win_valid, win_row, win_col,
               win_last, frame_last, tile_idx, busy
    );
endinterface

// File: rtl/upsample_tile_ctrl_win_pos_counter.sv
// Raster row/col counter over the 3x3 window positions of a tile.
// Also reports the address of the position that follows the current one,
// so the controller can pre-fetch the next window while streaming.
module win_pos_counter
    import upsample_tile_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       adv_i,
    output logic [1:0] row_o,
    output logic [1:0] col_o,
    output logic       last_o,
    output logic [3:0] next_addr_o
);
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] step_row_s;
    logic [1:0] step_col_s;

    // Position after one raster step; the last position wraps to (0,0) so
    // the counter never leaves the 3x3 range.
    always_comb begin
        step_row_s = row_q;
        step_col_s = col_q + 2'd1;
        if (col_q == 2'(WIN_PER_SIDE - 1)) begin
            step_col_s = 2'd0;
            if (row_q == 2'(WIN_PER_SIDE - 1)) begin
                step_row_s = 2'd0;
            end else begin
                step_row_s = row_q + 2'd1;
            end
        end else begin
            step_row_s = row_q;
        end
    end

    // Next-state selection: clear wins over advance, otherwise hold.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = 2'd0;
            col_d = 2'd0;
        end else if (adv_i) begin
            row_d = step_row_s;
            col_d = step_col_s;
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Position register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q <= 2'd0;
            col_q <= 2'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign last_o      = (row_q == 2'(WIN_PER_SIDE - 1)) && (col_q == 2'(WIN_PER_SIDE - 1));
    assign next_addr_o = win_addr(step_row_s, step_col_s);

endmodule

// File: rtl/upsample_tile_ctrl.sv
// Sequencer for the 4x4 tile input register of the upsampling path:
// accepts a tile, primes the register read port, then sweeps the 2x2 read
// window over all 9 positions under valid/ready backpressure.
module upsample_tile_ctrl
    import upsample_tile_ctrl_pkg::*;
#(
    parameter int FRAME_TILES = 16,
    parameter int TIDX_W      = 8,
    parameter int ADDR_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    upsample_tile_ctrl_if.master bus
);
    state_e            state_q;
    logic [TIDX_W-1:0] tile_idx_q;
    logic              accept_s;
    logic              fire_s;
    logic [1:0]        row_s;
    logic [1:0]        col_s;
    logic              pos_last_s;
    logic [3:0]        next_addr_s;
    logic [3:0]        cur_addr_s;
    logic              win_last_s;

    assign accept_s   = (state_q == ST_IDLE) && bus.tile_valid;
    assign fire_s     = (state_q == ST_SWEEP) && bus.win_ready;
    assign cur_addr_s = win_addr(row_s, col_s);
    assign win_last_s = (state_q == ST_SWEEP) && pos_last_s;

    win_pos_counter u_pos (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (accept_s),
        .adv_i       (fire_s),
        .row_o       (row_s),
        .col_o       (col_s),
        .last_o      (pos_last_s),
        .next_addr_o (next_addr_s)
    );

    // Control FSM and per-frame tile counter; a tile only counts once its
    // last window has been handed downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tile_idx_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_q <= ST_PRIME;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    state_q <= ST_SWEEP;
                end
                ST_SWEEP: begin
                    if (fire_s && pos_last_s) begin
                        state_q <= ST_IDLE;
                        if (tile_idx_q == TIDX_W'(FRAME_TILES - 1)) begin
                            tile_idx_q <= '0;
                        end else begin
                            tile_idx_q <= tile_idx_q + TIDX_W'(1);
                        end
                    end else begin
                        state_q <= ST_SWEEP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode. While streaming, the read address runs one position
    // ahead so the registered dout shows the next window on the next cycle;
    // while stalled it holds the current position so dout stays put.
    always_comb begin
        bus.tile_ready  = (state_q == ST_IDLE);
        bus.en_write_in = accept_s;
        bus.win_valid   = (state_q == ST_SWEEP);
        bus.busy        = (state_q != ST_IDLE);
        bus.win_row     = row_s;
        bus.win_col     = col_s;
        bus.win_last    = win_last_s;
        bus.frame_last  = win_last_s && (tile_idx_q == TIDX_W'(FRAME_TILES - 1));
        bus.tile_idx    = tile_idx_q;
        bus.addr_input  = '0;
        if (state_q == ST_SWEEP) begin
            if (fire_s) begin
                bus.addr_input = ADDR_W'(next_addr_s);
            end else begin
                bus.addr_input = ADDR_W'(cur_addr_s);
            end
        end else begin
            bus.addr_input = '0;
        end
    end

endmodule

// File: tb/tb_upsample_tile_ctrl.sv
// Self-checking bench for upsample_tile_ctrl with a behavioural 4x4 tile
// register and a window-sequence reference model.
module tb_upsample_tile_ctrl;
    localparam int FT     = 3;
    localparam int TIDX_W = 8;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    upsample_tile_ctrl_if #(.TIDX_W(TIDX_W), .ADDR_W(ADDR_W)) bus ();

    upsample_tile_ctrl #(.FRAME_TILES(FT), .TIDX_W(TIDX_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural tile register: write on en_write_in, dout registered from addr_input.
    logic [7:0]  treg [16];
    logic [7:0]  din  [16];
    logic [31:0] dout;
    always @(posedge clk) begin
        int a;
        a = int'(bus.addr_input) & 15;
        if (bus.en_write_in) begin
            for (int i = 0; i < 16; i++) treg[i] <= din[i];
        end
        dout <= {treg[a], treg[(a + 1) & 15], treg[(a + 4) & 15], treg[(a + 5) & 15]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] pix [16];
    int stall [9];
    int exp_idx = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr(input int k);
        return (k / 3) * 4 + (k % 3);
    endfunction

    function automatic logic [31:0] exp_win(input int k);
        int b;
        b = exp_addr(k);
        return {pix[b], pix[b + 1], pix[b + 4], pix[b + 5]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one tile and walk its 9 windows, with per-window stalls.
    // abort_at >= 0 pulls reset while that window is presented.
    task automatic send_tile(input bit hold, input int abort_at, output int acc_cyc);
        int waited;
        waited  = 0;
        acc_cyc = -1;
        for (int i = 0; i < 16; i++) din[i] = pix[i];
        bus.tile_valid = 1'b1;
        @(negedge clk);
        while (!bus.tile_ready && waited < 40) begin
            step();
            @(negedge clk);
            waited++;
        end
        if (!bus.tile_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.tile_valid = 1'b0;
            return;
        end
        check("accept_en_write", bus.en_write_in, 1);
        check("accept_tile_idx", bus.tile_idx, exp_idx);
        acc_cyc = cyc;
        step();
        if (!hold) bus.tile_valid = 1'b0;
        @(negedge clk);
        check("prime_ready", bus.tile_ready, 0);
        check("prime_win_valid", bus.win_valid, 0);
        check("prime_en_write", bus.en_write_in, 0);
        check("prime_addr", bus.addr_input, 0);
        check("prime_busy", bus.busy, 1);
        step();
        for (int k = 0; k < 9; k++) begin
            if (k == abort_at) begin
                bus.win_ready = 1'b0;
                bus.tile_valid = 1'b0;
                rst = 1'b0;
                #1;
                check("rst_win_valid", bus.win_valid, 0);
                check("rst_ready", bus.tile_ready, 1);
                check("rst_busy", bus.busy, 0);
                check("rst_addr", bus.addr_input, 0);
                check("rst_tile_idx", bus.tile_idx, exp_idx);
                step();
                rst = 1'b1;
                exp_idx = 0;
                return;
            end
            for (int s = 0; s < stall[k]; s++) begin
                bus.win_ready = 1'b0;
                @(negedge clk);
                check("stall_valid", bus.win_valid, 1);
                check("stall_row", bus.win_row, k / 3);
                check("stall_col", bus.win_col, k % 3);
                check("stall_addr", bus.addr_input, exp_addr(k));
                check("stall_dout", dout, exp_win(k));
                check("stall_last", bus.win_last, (k == 8));
                check("stall_en_write", bus.en_write_in, 0);
                step();
            end
            bus.win_ready = 1'b1;
            @(negedge clk);
            check("win_valid", bus.win_valid, 1);
            check("win_row", bus.win_row, k / 3);
            check("win_col", bus.win_col, k % 3);
            check("win_dout", dout, exp_win(k));
            check("win_last", bus.win_last, (k == 8));
            check("frame_last", bus.frame_last, (k == 8) && (exp_idx == FT - 1));
            check("win_tile_idx", bus.tile_idx, exp_idx);
            check("win_ready_low", bus.tile_ready, 0);
            check("win_en_write", bus.en_write_in, 0);
            if (k < 8) check("win_next_addr", bus.addr_input, exp_addr(k + 1));
            step();
        end
        exp_idx = (exp_idx + 1) % FT;
        check("end_ready", bus.tile_ready, 1);
        check("end_win_valid", bus.win_valid, 0);
    endtask

    task automatic rand_tile();
        for (int i = 0; i < 16; i++) pix[i] = 8'($urandom);
    endtask

    initial begin
        int a1;
        int a2;
        bus.tile_valid = 1'b0;
        bus.win_ready  = 1'b0;
        for (int i = 0; i < 16; i++) din[i] = 8'd0;
        for (int k = 0; k < 9; k++) stall[k] = 0;

        // 1. reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bus.tile_ready, 1);
        check("reset_win_valid", bus.win_valid, 0);
        check("reset_en_write", bus.en_write_in, 0);
        check("reset_addr", bus.addr_input, 0);
        check("reset_tile_idx", bus.tile_idx, 0);
        check("reset_busy", bus.busy, 0);
        step();
        rst = 1'b1;
        step();

        // 2. single tile, pixels 0..15, no backpressure
        for (int i = 0; i < 16; i++) pix[i] = 8'(i);
        send_tile(1'b0, -1, a1);
        step();

        // 3. backpressure on windows 3 and 7
        rand_tile();
        stall[3] = 4;
        stall[7] = 4;
        send_tile(1'b0, -1, a1);
        for (int k = 0; k < 9; k++) stall[k] = 0;

        // 4. back-to-back tiles with tile_valid held high (idx 2 then wrap to 0)
        rand_tile();
        send_tile(1'b1, -1, a1);
        rand_tile();
        send_tile(1'b0, -1, a2);
        check("b2b_period", 64'(a2 - a1), 64'd11);

        // 5. continue the frame: idx 1, 2
        rand_tile();
        send_tile(1'b0, -1, a1);
        rand_tile();
        send_tile(1'b0, -1, a1);

        // 6. reset during window 5 of a tile at idx 0, then a fresh tile
        rand_tile();
        send_tile(1'b0, 5, a1);
        step();
        check("post_rst_idx", bus.tile_idx, 0);
        rand_tile();
        send_tile(1'b0, -1, a1);

        // random backpressure tiles
        for (int t = 0; t < 3; t++) begin
            rand_tile();
            for (int k = 0; k < 9; k++) stall[k] = $urandom_range(0, 2);
            send_tile(1'b0, -1, a1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time bound in case the sequence above ever stops advancing
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
